// File: rtl/limiter_gain_ctrl.sv
// Limiter gain-envelope controller: THRESH/|x| target via restoring divider,
// attack/hold/release smoothing of a Q1.20 gain. Option: LIMITER_GAIN_CTRL_HOLD_EN.
module limiter_gain_ctrl #(
  parameter int WIDTH         = 32,
  parameter int FRAC          = 20,
  parameter int THRESH        = 524288,
  parameter int HOLD_SAMPLES  = 64,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_value,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [FRAC:0]    io_out_gain,
  output logic [1:0]       io_mode
);

  localparam int GW = FRAC + 1;
  localparam int DW = 33;
  localparam int CW = $clog2(GW);
  localparam logic [DW-1:0] UNITY = DW'(1) << FRAC;
  localparam logic [DW-1:0] TH = DW'(THRESH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPD, S_OUT} state_t;
  typedef enum logic [1:0] {M_IDLE, M_ATTACK, M_HOLD, M_RELEASE} mode_t;

  state_t state, state_nx;
  mode_t  mode;

  logic [GW-1:0] gain;
  logic [GW-1:0] tgt;
  logic [DW-2:0] rem;
  logic [DW-1:0] dvs;
  logic [GW-1:0] nbits;
  logic [CW-1:0] dcnt;

  logic [WIDTH-1:0] x_abs;
  logic             over;
  logic [DW-1:0]    trial;
  logic             ge;
  logic [DW-1:0]    g33, t33;
  logic [DW-1:0]    atk_step, atk_new;
  logic [DW-1:0]    rel_step, rel_new;
  logic             hold_nz;

  always_comb begin
    x_abs = io_in_value;
    if (io_in_value == MIN_NEG)
      x_abs = MAX_POS;
    else if (io_in_value[WIDTH-1])
      x_abs = -io_in_value;
  end

  assign over  = DW'(x_abs) > TH;
  assign trial = {rem, nbits[GW-1]};
  assign ge    = trial >= dvs;

  always_comb begin
    g33 = DW'(gain);
    t33 = DW'(tgt);
    atk_step = (g33 - t33) >> ATTACK_SHIFT;
    if (atk_step == '0) atk_step = DW'(1);
    atk_new = g33 - atk_step;
    if (atk_new < t33) atk_new = t33;
    rel_step = (UNITY - g33) >> RELEASE_SHIFT;
    if (rel_step == '0) rel_step = DW'(1);
    rel_new = g33 + rel_step;
    if (rel_new > UNITY) rel_new = UNITY;
  end

`ifdef LIMITER_GAIN_CTRL_HOLD_EN
  localparam int HCW = $clog2(HOLD_SAMPLES + 1);
  logic [HCW-1:0] hold_cnt;
  assign hold_nz = hold_cnt != '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hold_cnt <= '0;
    else if (state == S_UPD) begin
      if (t33 < g33)
        hold_cnt <= HCW'(HOLD_SAMPLES);
      else if (hold_nz)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end
`else
  // A negative hold length is meaningless; this is always false.
  assign hold_nz = HOLD_SAMPLES < 0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid)
          state_nx = over ? S_DIV : S_UPD;
      end
      S_DIV: begin
        if (dcnt == CW'(FRAC))
          state_nx = S_UPD;
      end
      S_UPD: state_nx = S_OUT;
      S_OUT: begin
        io_out_valid = 1'b1;
        if (io_out_ready)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gain  <= GW'(UNITY);
      mode  <= M_IDLE;
      tgt   <= '0;
      rem   <= '0;
      dvs   <= '0;
      nbits <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (io_in_valid) begin
            dvs   <= DW'(x_abs);
            // Dividend THRESH<<FRAC: high part preloaded, low FRAC+1 bits shifted in.
            rem   <= (DW-1)'(TH >> 1);
            nbits <= GW'(TH[0]) << FRAC;
            dcnt  <= '0;
            tgt   <= over ? '0 : GW'(UNITY);
          end
        end
        S_DIV: begin
          rem   <= ge ? (DW-1)'(trial - dvs) : (DW-1)'(trial);
          tgt   <= {tgt[GW-2:0], ge};
          nbits <= nbits << 1;
          dcnt  <= dcnt + 1'b1;
        end
        S_UPD: begin
          if (t33 < g33) begin
            gain <= GW'(atk_new);
            mode <= M_ATTACK;
          end else if (hold_nz) begin
            mode <= M_HOLD;
          end else if (g33 < UNITY) begin
            gain <= GW'(rel_new);
            mode <= M_RELEASE;
          end else begin
            mode <= M_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_out_gain = gain;
  assign io_mode     = mode;

endmodule

// File: tb/tb_limiter_gain_ctrl.sv
// Directed bench for limiter_gain_ctrl: vector table plus hold/release,
// backpressure and reset-in-flight sequences.
module tb_limiter_gain_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_value = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [20:0] io_out_gain;
  logic [1:0]  io_mode;

  int checks = 0;
  int failures = 0;

`ifdef LIMITER_GAIN_CTRL_HOLD_EN
  localparam int HOLD_N = 64;
`else
  localparam int HOLD_N = 0;
`endif

  limiter_gain_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_value  (io_in_value),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_gain  (io_out_gain),
    .io_mode      (io_mode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] value;
    logic [20:0] gain;
    logic [1:0]  mode;
    int          lat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the controller idle.
  task automatic send(input logic [31:0] v, output logic [20:0] g,
                      output logic [1:0] m, output int lat);
    io_in_valid = 1'b1;
    io_in_value = v;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    lat = 1;
    while (!io_out_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    g = io_out_gain;
    m = io_mode;
    @(posedge clock); #1;
  endtask

  task automatic send_chk(input string name, input logic [31:0] v,
                          input logic [20:0] eg, input logic [1:0] em,
                          input int el);
    logic [20:0] g;
    logic [1:0]  m;
    int          lat;
    send(v, g, m, lat);
    chk({name, " lat"}, lat, el);
    chk({name, " gain"}, g, eg);
    chk({name, " mode"}, m, em);
    chk({name, " in_ready"}, io_in_ready, 1);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int cnt;
    logic [20:0] g0;

    vt[0] = '{32'd262144,     21'd1048576, 2'd0, 2};
    vt[1] = '{32'd524288,     21'd1048576, 2'd0, 2};
    vt[2] = '{32'd524289,     21'd1048575, 2'd1, 23};
    vt[3] = '{32'd524289,     21'd1048574, 2'd1, 23};
    vt[4] = '{32'd1048576,    21'd917503,  2'd1, 23};
    vt[5] = '{32'hFFF0_0000,  21'd819200,  2'd1, 23};
    vt[6] = '{32'h8000_0000,  21'd614464,  2'd1, 23};
    vt[7] = '{32'h7FFF_FFFF,  21'd460912,  2'd1, 23};

    #2 reset = 1'b1;
    #1;
    chk("por gain", io_out_gain, 1048576);
    chk("por mode", io_mode, 0);
    chk("por in_ready", io_in_ready, 1);
    chk("por out_valid", io_out_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++)
      send_chk($sformatf("vec%0d", i), vt[i].value, vt[i].gain,
               vt[i].mode, vt[i].lat);

    // Asynchronous reset between edges, checked before any edge.
    #3 reset = 1'b1;
    #1;
    chk("async gain", io_out_gain, 1048576);
    chk("async mode", io_mode, 0);
    chk("async in_ready", io_in_ready, 1);
    chk("async out_valid", io_out_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    send_chk("atk1", 32'd1048576, 21'd917504, 2'd1, 23);
    send_chk("atk2", 32'd1048576, 21'd819200, 2'd1, 23);

    do_reset();
    send_chk("h_atk", 32'd1048576, 21'd917504, 2'd1, 23);
    for (int k = 0; k < HOLD_N; k++)
      send_chk($sformatf("hold%0d", k), 32'd0, 21'd917504, 2'd2, 2);
    send_chk("rel1", 32'd0, 21'd918016, 2'd3, 2);
    send_chk("rel2", 32'd0, 21'd918526, 2'd3, 2);

    do_reset();
    send_chk("nu_atk", 32'd524289, 21'd1048575, 2'd1, 23);
    for (int k = 0; k < HOLD_N; k++)
      send_chk($sformatf("nu_hold%0d", k), 32'd0, 21'd1048575, 2'd2, 2);
    send_chk("nu_rel", 32'd0, 21'd1048576, 2'd3, 2);
    send_chk("nu_idle", 32'd0, 21'd1048576, 2'd0, 2);

    // Backpressure on the output side.
    do_reset();
    io_out_ready = 1'b0;
    io_in_valid = 1'b1;
    io_in_value = 32'd1048576;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    chk("bp in_ready drop", io_in_ready, 0);
    cnt = 1;
    while (!io_out_valid && cnt < 100) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk("bp lat", cnt, 23);
    g0 = io_out_gain;
    chk("bp gain", g0, 917504);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk($sformatf("bp%0d valid", k), io_out_valid, 1);
      chk($sformatf("bp%0d gain", k), io_out_gain, 917504);
      chk($sformatf("bp%0d in_ready", k), io_in_ready, 0);
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp done valid", io_out_valid, 0);
    chk("bp done in_ready", io_in_ready, 1);

    // Reset during the 10th divide cycle.
    io_in_valid = 1'b1;
    io_in_value = 32'd1048576;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #4 reset = 1'b1;
    #1;
    chk("rdiv gain", io_out_gain, 1048576);
    chk("rdiv mode", io_mode, 0);
    chk("rdiv in_ready", io_in_ready, 1);
    chk("rdiv out_valid", io_out_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (io_out_valid) cnt++;
    end
    chk("rdiv no output", cnt, 0);
    chk("rdiv idle", io_in_ready, 1);
    send_chk("rdiv after", 32'd1048576, 21'd917504, 2'd1, 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/limiter_gain_ctrl.md
# limiter_gain_ctrl

Gain-envelope controller for the audio limiter datapath. It takes the signed Q11.20 sample stream and computes a target gain of THRESH/|x| with a sequential restoring divider. It then moves a Q1.20 gain register toward that target under an attack/hold/release envelope. The gain drives the limiter's multiplier stage; a valid/ready handshake lets the sample source and gain consumer stall independently.

## Interface
- `WIDTH`, 32: sample width, signed two's complement.
- `FRAC`, 20: fractional bits of the sample and gain formats; unity gain = 1<<FRAC = 1048576.
- `THRESH`, 524288: limit threshold magnitude (0.5 in Q11.20); must satisfy 0 < THRESH < 2^31.
- `HOLD_SAMPLES`, 64: samples held after the last over-threshold sample before release.
- `ATTACK_SHIFT`, 2: attack step = (gain − target) >> ATTACK_SHIFT.
- `RELEASE_SHIFT`, 8: release step = (unity − gain) >> RELEASE_SHIFT.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_in_valid`  in  1  sample offered.
- `io_in_ready`  out  1  controller can accept a sample.
- `io_in_value`  in  WIDTH  signed Q11.20 sample.
- `io_out_valid`  out  1  new gain published.
- `io_out_ready`  in  1  consumer takes the gain.
- `io_out_gain`  out  FRAC+1  current unsigned Q1.20 gain, always driven.
- `io_mode`  out  2  envelope mode: 0 IDLE, 1 ATTACK, 2 HOLD, 3 RELEASE.

## Operation
- Control FSM states:
  - S_IDLE: `io_in_ready` = 1.
  - S_DIV: sequential divide.
  - S_UPD: gain update, one cycle.
  - S_OUT: `io_out_valid` = 1.
- Accept on `io_in_valid && io_in_ready`. The sample is captured and abs = |x|, saturated: −2^31 → 2^31−1.
- Target gain:
  - If abs ≤ THRESH: target = unity. Go to S_UPD and skip the divider.
  - Otherwise: go to S_DIV. Compute target = floor((THRESH << FRAC) / abs) by restoring division, one quotient bit per cycle, MSB first, 21 cycles exactly. Since the result is < unity, bit 20 is always 0.
- S_UPD, evaluated on the target computed for this sample:
  - target < gain: gain −= max(1, (gain − target) >> ATTACK_SHIFT), clamped so gain ≥ target. Hold counter = HOLD_SAMPLES. Mode = ATTACK.
  - target ≥ gain and hold counter > 0: gain unchanged, counter decrements. Mode = HOLD.
  - target ≥ gain, counter = 0, gain < unity: gain += max(1, (unity − gain) >> RELEASE_SHIFT), clamped to ≤ unity. Mode = RELEASE.
  - gain = unity and counter = 0: mode = IDLE.
  - Release always heads to unity, not target. Attack re-engages on the next over-threshold sample.
- S_OUT holds `io_out_valid` with a stable `io_out_gain` until `io_out_ready`, then returns to S_IDLE.
- Processing does not overlap: no new sample is accepted before the output handshake completes.
- All arithmetic is unsigned on 33-bit intermediates; no step can wrap.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = S_IDLE, gain = 1048576, hold counter = 0.
  - `io_mode` = 0, `io_in_ready` = 1, `io_out_valid` = 0.
- Latency from the accept edge to `io_out_valid` high:
  - after the 2nd rising edge on the bypass path;
  - after the 23rd rising edge on the divide path (21 DIV + 1 UPD + 1 transition).
- `io_in_ready` is registered and drops on the edge after acceptance.
- Output handshake with `io_out_ready` held high: completes on the first S_OUT edge; `io_in_ready` returns one cycle later.
- `io_out_gain` and `io_mode` change only on the S_UPD→S_OUT edge.
- Reset asserted mid-divide or mid-output: the partial quotient is discarded and all reset values apply immediately. No output handshake is emitted for the in-flight sample.

## Configuration
- `LIMITER_GAIN_CTRL_HOLD_EN` defined: the HOLD stage and hold counter exist as described.
- Not defined:
  - The counter is removed and HOLD (mode 2) is never reported.
  - target ≥ gain with gain < unity goes directly to RELEASE.
  - All other behaviour and latency are identical.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> gain 1048576, mode 0, `io_in_ready` 1, `io_out_valid` 0, with no clock edge needed.
- Sub-threshold: input 262144 -> `io_out_valid` after 2 edges, gain 1048576, mode IDLE.
- Over-threshold: input 1048576 from reset -> target 524288, valid after 23 edges, gain 917504, mode ATTACK. Repeating it gives 819200.
- Negative saturation: input −2147483648 -> abs 2147483647, target 256, gain steps toward 256, mode ATTACK.
- Hold/release (macro defined): one attack sample, then 64 inputs of 0 -> gain unchanged, mode HOLD. The 65th -> mode RELEASE, gain += (1048576 − g) >> 8. Without the macro, the first 0 input releases.
- Backpressure and reset: hold `io_out_ready` low 5 cycles -> `io_out_valid` and gain stable, `io_in_ready` 0. Assert reset on DIV cycle 10 -> reset values, no output handshake.
